// File: rtl/decoder_if.sv
// decoder_if -- select/enable bundle for the registered 2-to-4 decoder.
//
// Signals:
//   en     sample enable, driven by the producer of the select
//   w, z   2-bit select (w = MSB, z = LSB)
//   p..s   registered one-hot enables (p={w,z}=00 ... s={w,z}=11)
//   valid  set once an enabled sample has been captured since reset
//
// Modports:
//   master  drives en/w/z and observes the decoded outputs
//   slave   the decoder itself
interface decoder_if;
  logic en;
  logic w;
  logic z;
  logic p;
  logic q;
  logic r;
  logic s;
  logic valid;

  modport master (
    output en, w, z,
    input  p, q, r, s, valid
  );

  modport slave (
    input  en, w, z,
    output p, q, r, s, valid
  );
endinterface

// File: rtl/decoder.sv
// decoder -- registered 2-to-4 one-hot decoder.
//
// Samples the select {w,z} on a rising clk edge when en=1 and drives
// exactly one of p/q/r/s from flops, so downstream logic sees
// glitch-free, clock-aligned enables. valid rises with the first
// enabled sample and stays high until reset; p..s are all 0 before that.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears p..s and valid)
//   bus    decoder_if.slave: en/w/z in, p/q/r/s/valid out
module decoder (
  input  logic       clk,
  input  logic       rst_n,
  decoder_if.slave   bus
);

  // onehot bit index equals the binary select value: 0=p, 1=q, 2=r, 3=s
  logic [3:0] decode;
  logic [3:0] onehot_d;
  logic [3:0] onehot_q;
  logic       valid_d;
  logic       valid_q;

  // Each bit is an AND of literal-matched select bits. Plain boolean
  // terms (rather than a case with a default) let an X on w/z reach the
  // flops in simulation instead of being silently decoded to something.
  for (genvar gi = 0; gi < 4; gi++) begin : g_decode
    localparam logic [1:0] CODE = 2'(gi);
    assign decode[gi] = (bus.w ~^ CODE[1]) & (bus.z ~^ CODE[0]);
  end

  always_comb begin
    onehot_d = onehot_q;
    valid_d  = valid_q;
    if (bus.en) begin
      onehot_d = decode;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_q <= 4'b0000;
      valid_q  <= 1'b0;
    end else begin
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.p     = onehot_q[0];
  assign bus.q     = onehot_q[1];
  assign bus.r     = onehot_q[2];
  assign bus.s     = onehot_q[3];
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_decoder.sv
// tb_decoder -- directed and random checks for the registered decoder.
// Observed vectors are {p,q,r,s,valid}.
module tb_decoder;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;

  decoder_if bus ();

  decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end else begin
      $display("ok   %s: %b", tag, got);
    end
  endtask

  function automatic logic [4:0] obs();
    return {bus.p, bus.q, bus.r, bus.s, bus.valid};
  endfunction

  // expected {p,q,r,s} for a select
  function automatic logic [3:0] dec(input logic w, input logic z);
    return {~w & ~z, ~w & z, w & ~z, w & z};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic w, input logic z);
    bus.en = en;
    bus.w  = w;
    bus.z  = z;
  endtask

  logic [3:0] m_oh;
  logic       m_valid;
  logic [1:0] codes [4];

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    codes[0] = 2'b00; codes[1] = 2'b01; codes[2] = 2'b10; codes[3] = 2'b11;

    // Reset held with en=1, select 11
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1);
    #1;
    chk("reset_async", obs(), 5'b00000);
    tick();
    chk("reset_cyc1", obs(), 5'b00000);
    tick();
    chk("reset_cyc2", obs(), 5'b00000);

    // Release mid-cycle, then sweep all codes with en=1
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, codes[i][1], codes[i][0]);
      tick();
      chk($sformatf("sweep_%b", codes[i]), obs(), {dec(codes[i][1], codes[i][0]), 1'b1});
    end

    // Hold: capture 10, then toggle select with en=0
    drive(1'b1, 1'b1, 1'b0);
    tick();
    chk("hold_capture", obs(), 5'b00101);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, codes[i][1], codes[i][0]);
      tick();
      chk($sformatf("hold_%b", codes[i]), obs(), 5'b00101);
    end

    // Mid-operation reset pulse
    drive(1'b1, 1'b1, 1'b1);
    tick();
    chk("pre_rst_s", obs(), 5'b00011);
    drive(1'b0, 1'b1, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_async", obs(), 5'b00000);
    #4;
    rst_n = 1'b1;
    tick();
    chk("post_rst_en0_a", obs(), 5'b00000);
    tick();
    chk("post_rst_en0_b", obs(), 5'b00000);
    drive(1'b1, 1'b0, 1'b1);
    tick();
    chk("post_rst_q", obs(), 5'b01001);

    // Random en/w/z; model tracks last enabled sample
    m_oh    = 4'b0100;
    m_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (bus.en) begin
        m_oh    = dec(bus.w, bus.z);
        m_valid = 1'b1;
      end
      tick();
      chk($sformatf("rand_%0d", i), obs(), {m_oh, m_valid});
      chk($sformatf("onehot_%0d", i), 5'($countones({bus.p, bus.q, bus.r, bus.s})), 5'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/decoder.md
# decoder

Registered 2-to-4 one-hot decoder. It samples a 2-bit select (w = MSB, z = LSB) and asserts exactly one of four outputs p, q, r, s. It is a small leaf block used wherever a binary select must drive one-hot enables. Its outputs come from flops so downstream logic sees glitch-free, clock-aligned enables.

## Interface
- No parameters; widths fixed.
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst_n  input  1  reset, asynchronous and active-low.
- en  input  1  sample enable; when 1, w/z are captured at the next rising clk edge.
- w  input  1  select MSB.
- z  input  1  select LSB.
- p  output  1  one-hot bit 0; asserted for {w,z}=00.
- q  output  1  one-hot bit 1; asserted for {w,z}=01.
- r  output  1  one-hot bit 2; asserted for {w,z}=10.
- s  output  1  one-hot bit 3; asserted for {w,z}=11.
- valid  output  1  1 once at least one enabled sample has been captured since reset.

## Operation
- Decode mapping, active-high:
  - p = ~w & ~z
  - q = ~w & z
  - r = w & ~z
  - s = w & z
- On a rising clk with en=1, the decoded value of the current w/z is loaded into the p/q/r/s registers, and valid is set to 1.
- On a rising clk with en=0, p/q/r/s and valid hold their values.
- After the first enabled sample, exactly one of p/q/r/s is 1 at all times until the next reset (one-hot invariant).
- Before the first enabled sample after reset, all four outputs are 0 and valid=0. Downstream logic qualifies p/q/r/s with valid.
- No combinational path from w/z/en to any output.
- X on w or z while en=1 must not be masked silently. In simulation it propagates to the outputs; synthesis needs no special handling.

## Timing
- Latency is 1 clk: w/z present with en=1 before edge N appear on p/q/r/s after edge N.
- Throughput is one new select per cycle; back-to-back en=1 cycles each update the outputs.
- Reset values: p=0, q=0, r=0, s=0, valid=0.
- Reset is applied asynchronously on falling rst_n, independent of clk.
- Reset release is synchronized by the normal clocking: the first edge with rst_n=1 and en=1 loads the outputs.
- Reset asserted mid-operation clears all outputs and valid immediately. After release, the outputs stay 0 until the next enabled edge.
- en=1 coincident with the clock edge on which rst_n deasserts: the sample is taken, because rst_n is already high at that edge.
- w/z changing while en=0 has no effect on the outputs.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with w=1, z=1, en=1 -> p,q,r,s,valid all 0. Outputs stay 0 asynchronously when rst_n drops between clock edges.
- Full sweep: en=1, apply {w,z}=00, 01, 10, 11 on successive cycles -> one cycle later, outputs {p,q,r,s} = 1000, 0100, 0010, 0001 in turn, and valid=1 from the first sample onward.
- Hold: capture {w,z}=10, then set en=0 and toggle w/z through all codes for 4 cycles -> r=1, others 0 throughout.
- Mid-operation reset: with s=1, pulse rst_n low for half a cycle -> all outputs 0 immediately, valid=0. With en=0 after release, outputs remain 0 until en=1 with {w,z}=01, which gives q=1 on the next edge.
- One-hot check: 200 random cycles of en/w/z -> after the first enabled sample, p+q+r+s == 1 every cycle, and the outputs match the decode of the last enabled sample.
